// File: rtl/fa_serial_arbiter.sv
// fa_serial_arbiter
//
// Shares one external 1-bit full-adder cell between two requesters. Each
// requester submits a WIDTH-bit add (a + b + cin). A round-robin arbiter picks
// one request, and the block then drives the adder bit-serially, LSB first,
// for WIDTH cycles. The running carry is kept in a flop between bits. The
// finished sum, carry-out and requester id are presented on a valid/ready
// response channel.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin operands and carry-in for requester N
//   fa_a, fa_b, fa_c         drive the external full adder's a, b, carry-in
//   fa_sum, fa_cout          read back from the external full adder
//   rsp_valid / rsp_ready    response handshake
//   rsp_sum, rsp_cout        result: {rsp_cout, rsp_sum} = a + b + cin
//   rsp_id                   requester that issued the result

module fa_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_cout,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
);

    // Bit-counter width, derived from WIDTH only.
    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   opA_q;
    logic [WIDTH-1:0]   opB_q;
    // Holds the sum bits already produced, bit 0 ends up at position 0 after
    // WIDTH-1 shifts; the final bit is merged in straight from fa_sum.
    logic [WIDTH-2:0]   sum_q;
    logic               carry_q;
    logic [CNTW-1:0]    cnt_q;
    logic               id_q;
    logic               lastGrant_q;
    logic               rspValid_q;
    logic [WIDTH-1:0]   rspSum_q;
    logic               rspCout_q;
    logic               rspId_q;

    logic               inIdle;
    logic               inRun;
    logic               grantId;
    logic               accept;
    logic [WIDTH-1:0]   opA_d;
    logic [WIDTH-1:0]   opB_d;
    logic               cin_d;
    logic [WIDTH-1:0]   sum_d;
    logic               lastBit;

    // Gating with rst keeps ready and the adder inputs low while reset is
    // applied, even though the state register only clears on the next edge.
    assign inIdle = (state_q == IDLE) && !rst;
    assign inRun  = (state_q == RUN)  && !rst;

    // Requester 1 wins when it is the only one asking, or when both ask and
    // requester 0 was served last. Otherwise requester 0 wins.
    assign grantId = req1_valid && (!req0_valid || !lastGrant_q);

    assign req0_ready = inIdle && req0_valid && !grantId;
    assign req1_ready = inIdle && grantId;
    assign accept     = req0_ready || req1_ready;

    assign opA_d = grantId ? req1_a   : req0_a;
    assign opB_d = grantId ? req1_b   : req0_b;
    assign cin_d = grantId ? req1_cin : req0_cin;

    assign fa_a = inRun && opA_q[0];
    assign fa_b = inRun && opB_q[0];
    assign fa_c = inRun && carry_q;

    // Current adder sum bit joins the collected bits at the MSB side.
    assign sum_d   = {fa_sum, sum_q};
    assign lastBit = (cnt_q == CNTW'(WIDTH - 1));

    assign rsp_valid = rspValid_q;
    assign rsp_sum   = rspSum_q;
    assign rsp_cout  = rspCout_q;
    assign rsp_id    = rspId_q;

    // Controller: accept in IDLE, shift one bit per cycle in RUN, hold the
    // registered response in DONE until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            lastGrant_q <= 1'b1;
            rspValid_q  <= 1'b0;
            rspSum_q    <= '0;
            rspCout_q   <= 1'b0;
            rspId_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opA_q       <= opA_d;
                        opB_q       <= opB_d;
                        carry_q     <= cin_d;
                        id_q        <= grantId;
                        lastGrant_q <= grantId;
                        cnt_q       <= '0;
                        sum_q       <= '0;
                        state_q     <= RUN;
                    end
                end

                RUN: begin
                    sum_q   <= sum_d[WIDTH-1:1];
                    carry_q <= fa_cout;
                    opA_q   <= {1'b0, opA_q[WIDTH-1:1]};
                    opB_q   <= {1'b0, opB_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CNTW'(1);
                    if (lastBit) begin
                        rspSum_q   <= sum_d;
                        rspCout_q  <= fa_cout;
                        rspId_q    <= id_q;
                        rspValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end

                DONE: begin
                    // Returning to IDLE first means no new request can be
                    // taken in the same cycle as the response handshake.
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fa_serial_arbiter.md
Name: fa_serial_arbiter

Overview:
- Controller that time-shares a single 1-bit full-adder cell between two requesters, each submitting WIDTH-bit add operations.
- Arbitrates round-robin, then sequences the adder bit-serially, LSB first, holding the carry in a flop between bits.
- Returns the sum, the carry-out and the requester ID on a valid/ready response channel.
- Sits between requesting datapath blocks and an external FullAdder instance. The block drives its inputs and reads its outputs combinationally.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- CNTW, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  operand A, requester 0.
- req0_b  input  WIDTH  operand B, requester 0.
- req0_cin  input  1  carry-in, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as the req0_* ports, for requester 1.
- fa_a  output  1  to full adder input a.
- fa_b  output  1  to full adder input b.
- fa_c  output  1  to full adder carry input c.
- fa_sum  input  1  from full adder Sum.
- fa_cout  input  1  from full adder Cout.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  result sum.
- rsp_cout  output  1  final carry-out.
- rsp_id  output  1  requester that issued the result.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all flops update only on the clk rising edge.
- Reset values: state=IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, carry flop=0, bit counter=0, last_grant=1 (so requester 0 wins the first tie).
- During rst high: reqN_ready=0 and fa_a/fa_b/fa_c=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational. It is 1 only for the granted requester, only in IDLE, and only when rst=0.
  - Grant: if exactly one reqN_valid is high, grant it. If both are high, grant the one not equal to last_grant.
  - On handshake (valid & ready): latch a, b, cin and id into shift/operand registers; last_grant <= id; counter <= 0; go to RUN.
  - Ready may depend on valid. Valid must not depend on ready.
- RUN (WIDTH cycles):
  - fa_a = a_reg[0], fa_b = b_reg[0], fa_c = carry.
  - Each cycle: shift fa_sum into sum_reg MSB-side (right shift), carry <= fa_cout, shift a_reg and b_reg right by 1, counter++.
  - When counter == WIDTH-1: go to DONE. Registered outputs: rsp_sum <= assembled sum, rsp_cout <= fa_cout, rsp_id <= id, rsp_valid <= 1.
- DONE:
  - rsp_valid held at 1; rsp_sum, rsp_cout and rsp_id stable until rsp_ready=1.
  - On handshake: rsp_valid <= 0 and go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Outside RUN: fa_a, fa_b and fa_c are 0.
- Latency: request handshake in cycle T gives rsp_valid=1 in cycle T+WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(WIDTH+1). Never saturates.
- Request inputs are ignored outside IDLE. A requester whose valid drops before its grant loses nothing.
- Reset mid-operation (RUN or DONE): the operation is discarded, no response is produced, and all state returns to reset values on the next edge.

Test Plan:
- WIDTH=8, req0 a=0xA5 b=0x3C cin=0 -> rsp_sum=0xE1, rsp_cout=0, rsp_id=0, rsp_valid exactly 9 cycles after accept.
- req1 a=0xFF b=0x01 cin=0 -> rsp_sum=0x00, rsp_cout=1, rsp_id=1. Also req0 a=0x7F b=0x80 cin=1 -> rsp_sum=0x00, rsp_cout=1.
- Both valid held continuously, each issuing 3 ops -> rsp_id sequence 0,1,0,1,0,1. No grant while busy; ready pulses only in IDLE.
- rsp_ready held low 5 cycles after rsp_valid -> sum/cout/id stable and both readys stay 0. Release -> IDLE next cycle, then next accept.
- rst asserted at RUN bit 3 -> rsp_valid=0, fa_* =0; after release, with both valid, req0 granted first. The aborted op produces no response.
- Cycle-check fa_a/fa_b/fa_c against the LSB-first operand bits and the propagated carry for a=0x0F b=0x01 -> carry chain 1,1,1,1,0,0,0,0.
